// File: rtl/asin_deg_if.sv
// -----------------------------------------------------------------------------
// asin_deg_if
//   Request/response bundle between the calculator datapath and the asin_deg
//   block.
//
//   Handshake (start/done/error):
//     - master raises start for one cycle with a valid; the block samples it
//       only while idle, and any start seen while busy is dropped.
//     - the block raises done for exactly one cycle when result is valid;
//       error is high in that same cycle for invalid operands and low at
//       all other times.
//     - result holds its value until the next completed operation.
//
//   Signals:
//     start  : one-cycle request (master -> block)
//     a      : IEEE754 single operand (master -> block)
//     result : IEEE754 single, arcsin(a) in degrees (block -> master)
//     error  : invalid-operand flag, qualified by done (block -> master)
//     done   : one-cycle completion pulse (block -> master)
// -----------------------------------------------------------------------------
interface asin_deg_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] result;
    logic        error;
    logic        done;

    modport master (
        output start,
        output a,
        input  result,
        input  error,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        output result,
        output error,
        output done
    );
endinterface

// File: rtl/asin_deg.sv
// -----------------------------------------------------------------------------
// asin_deg
//   arcsin of an IEEE754 single in [-1,1], returned in degrees as IEEE754.
//   Flow: unpack to signed fixed point, double-iteration arcsine CORDIC
//   (one iteration per cycle), radian-to-degree scaling, repack to float.
//
//   Ports:
//     clk         : rising-edge clock
//     rst         : synchronous, active-low reset
//     bus         : asin_deg_if.slave (start, a, result, error, done)
//     dbg_state_o : current FSM state encoding
//
//   Parameters:
//     ITER : CORDIC iterations (8..16)
//     FRAC : fraction bits of the internal fixed point; datapath is FRAC+4 wide
// -----------------------------------------------------------------------------
module asin_deg #(
    parameter int ITER = 14,
    parameter int FRAC = 16
) (
    input  logic       clk,
    input  logic       rst,
    asin_deg_if.slave  bus,
    output logic [2:0] dbg_state_o
);
    localparam int W  = FRAC + 4;    // CORDIC datapath width
    localparam int DW = FRAC + 12;   // degree value: sign + 7 integer bits + margin
    localparam int PW = W + 18;      // z * degree constant product width
    localparam int LW = $clog2(DW);

    localparam logic [31:0] NAN_Q  = 32'hFFC00000;
    localparam logic [31:0] POS_90 = 32'h42B40000;
    localparam logic [31:0] NEG_90 = 32'hC2B40000;
    localparam logic signed [W-1:0] ONE = {3'b000, 1'b1, {FRAC{1'b0}}};
    // 180/pi in Q6.10
    localparam logic signed [17:0] DEG_K = 18'sd58672;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_CORDIC = 3'd2,
        S_SCALE  = 3'd3,
        S_PACK   = 3'd4,
        S_OUTPUT = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          a_q, a_d;
    logic signed [W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d, t_q, t_d;
    logic [3:0]           iter_q, iter_d;
    logic signed [DW-1:0] deg_q, deg_d;
    logic [31:0]          res_q, res_d;      // staged answer awaiting OUTPUT
    logic                 err_q, err_d;
    logic [31:0]          result_q, result_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;

    // atan(2^-i) stored in Q30 and trimmed to FRAC fraction bits.
    function automatic logic signed [W-1:0] atan_rom(input logic [3:0] idx);
        logic [31:0] q30;
        case (idx)
            4'd0:    q30 = 32'd843314856;
            4'd1:    q30 = 32'd497837829;
            4'd2:    q30 = 32'd263043836;
            4'd3:    q30 = 32'd133525158;
            4'd4:    q30 = 32'd67021686;
            4'd5:    q30 = 32'd33543515;
            4'd6:    q30 = 32'd16775850;
            4'd7:    q30 = 32'd8388437;
            4'd8:    q30 = 32'd4194282;
            4'd9:    q30 = 32'd2097149;
            4'd10:   q30 = 32'd1048575;
            4'd11:   q30 = 32'd524287;
            4'd12:   q30 = 32'd262143;
            4'd13:   q30 = 32'd131071;
            4'd14:   q30 = 32'd65535;
            default: q30 = 32'd32767;
        endcase
        return W'(q30 >> (30 - FRAC));
    endfunction

    // ---------------- unpack datapath ----------------
    logic                 a_sign;
    logic [7:0]           a_exp;
    logic [22:0]          a_man;
    logic [7:0]           sh_amt;
    logic [23:0]          sig_sh;
    logic signed [W-1:0]  t0_mag, t0;

    assign a_sign = a_q[31];
    assign a_exp  = a_q[30:23];
    assign a_man  = a_q[22:0];

    always_comb begin
        // (1.m) is Q1.23; shifting by (127-e) aligns it, a further 23-FRAC
        // drops to FRAC fraction bits.
        sh_amt = 8'd127 - a_exp + 8'(23 - FRAC);
        sig_sh = {1'b1, a_man} >> sh_amt;
        t0_mag = W'(sig_sh);
        t0     = a_sign ? -t0_mag : t0_mag;
    end

    // ---------------- CORDIC step ----------------
    logic                 d_pos;
    logic signed [W-1:0]  xs0, ys0, x1, y1, xs1, ys1, x2, y2, ang, z_n, t_n;

    always_comb begin
        d_pos = ((y_q <= t_q) == !x_q[W-1]);
        xs0   = x_q >>> iter_q;
        ys0   = y_q >>> iter_q;
        x1    = d_pos ? (x_q - ys0) : (x_q + ys0);
        y1    = d_pos ? (y_q + xs0) : (y_q - xs0);
        xs1   = x1 >>> iter_q;
        ys1   = y1 >>> iter_q;
        x2    = d_pos ? (x1 - ys1) : (x1 + ys1);
        y2    = d_pos ? (y1 + xs1) : (y1 - xs1);
        ang   = atan_rom(iter_q) <<< 1;
        z_n   = d_pos ? (z_q + ang) : (z_q - ang);
        // two rotations grow |(x,y)| by (1+2^-2i); track that in t
        t_n   = t_q + (t_q >>> {iter_q, 1'b0});
    end

    // ---------------- scale and pack ----------------
    logic signed [PW-1:0] prod;
    logic                 deg_neg;
    logic [DW-1:0]        deg_mag;
    logic [LW-1:0]        lead;
    logic [DW+22:0]       norm;
    logic [7:0]           pk_exp;
    logic [31:0]          packed_res;

    assign prod = z_q * DEG_K;

    always_comb begin
        deg_neg = deg_q[DW-1];
        deg_mag = deg_neg ? -deg_q : deg_q;
        lead    = '0;
        for (int i = 0; i < DW; i++) begin
            if (deg_mag[i]) lead = LW'(i);
        end
        // leading one lands on bit DW+22; the 23 bits below it are the mantissa
        norm       = {deg_mag, 23'b0} << (LW'(DW - 1) - lead);
        pk_exp     = 8'(lead) + 8'(127 - FRAC);
        packed_res = (deg_mag == '0) ? 32'h0000_0000
                                     : {deg_neg, pk_exp, norm[DW+21 -: 23]};
    end

    logic unused_bits;
    assign unused_bits = ^{prod[9:0], norm[DW+22], norm[DW-2:0]};

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        t_d      = t_q;
        iter_d   = iter_q;
        deg_d    = deg_q;
        res_d    = res_q;
        err_d    = err_q;
        result_d = result_q;
        error_d  = error_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                done_d  = 1'b0;
                error_d = 1'b0;
                // the idle cycle that retires a done pulse does not accept a
                // request, so a held start repeats every ITER+6 cycles
                if (bus.start && !done_q) begin
                    a_d     = bus.a;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (a_exp == 8'hFF || a_exp > 8'd127 ||
                    (a_exp == 8'd127 && a_man != '0)) begin
                    res_d   = NAN_Q;
                    err_d   = 1'b1;
                    state_d = S_OUTPUT;
                end else if (a_exp == 8'd127) begin
                    res_d   = a_sign ? NEG_90 : POS_90;
                    err_d   = 1'b0;
                    state_d = S_OUTPUT;
                end else if (a_exp < 8'd112) begin
                    res_d   = 32'h0000_0000;
                    err_d   = 1'b0;
                    state_d = S_OUTPUT;
                end else begin
                    x_d     = ONE;
                    y_d     = '0;
                    z_d     = '0;
                    t_d     = t0;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_CORDIC;
                end
            end
            S_CORDIC: begin
                x_d    = x2;
                y_d    = y2;
                z_d    = z_n;
                t_d    = t_n;
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'(ITER - 1)) state_d = S_SCALE;
            end
            S_SCALE: begin
                deg_d   = prod[DW+9:10];
                state_d = S_PACK;
            end
            S_PACK: begin
                res_d   = packed_res;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                result_d = res_q;
                error_d  = err_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            t_q      <= '0;
            iter_q   <= '0;
            deg_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            t_q      <= t_d;
            iter_q   <= iter_d;
            deg_q    <= deg_d;
            res_q    <= res_d;
            err_q    <= err_d;
            result_q <= result_d;
            error_q  <= error_d;
            done_q   <= done_d;
        end
    end

    assign bus.result  = result_q;
    assign bus.error   = error_q;
    assign bus.done    = done_q;
    assign dbg_state_o = state_q;
endmodule
